// File: rtl/timer_scheduler.sv
// rtl/timer_scheduler.sv - round-robin scheduler sharing one countdown timer among N_REQ requesters
module timer_scheduler #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_value,
  input  logic                   hold,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       done,
  output logic                   busy,
  output logic [WIDTH-1:0]       tmr_value,
  output logic                   tmr_valid,
  output logic                   tmr_enable,
  input  logic [WIDTH-1:0]       tmr_count
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [IW-1:0] PTR_INIT = IW'(N_REQ - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_RUN   = 3'd2,
    S_DONE  = 3'd3,
    S_ABORT = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [IW-1:0]   owner_q, owner_d;
  logic [IW-1:0]   ptr_q, ptr_d;

  logic            win_found;
  logic [IW-1:0]   win_idx;
  logic [WIDTH-1:0] owner_value;
  logic            owner_req;
  logic [N_REQ-1:0] owner_onehot;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      owner_q <= '0;
      ptr_q   <= PTR_INIT;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
    end
  end

  // Round-robin search starting just after the last served requester.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    for (int i = 1; i <= N_REQ; i++) begin
      int idx;
      idx = (int'(ptr_q) + i) % N_REQ;
      if (!win_found && req[idx]) begin
        win_found = 1'b1;
        win_idx   = IW'(idx);
      end
    end
  end

  always_comb begin
    owner_value  = '0;
    owner_req    = 1'b0;
    owner_onehot = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (owner_q == IW'(i)) begin
        owner_value     = req_value[i*WIDTH +: WIDTH];
        owner_req       = req[i];
        owner_onehot[i] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      S_IDLE: begin
        if (win_found) begin
          owner_d = win_idx;
          state_d = S_LOAD;
        end
      end
      S_LOAD: state_d = S_RUN;
      S_RUN: begin
        // Completion takes precedence over a same-cycle cancel.
        if (tmr_count == '0) begin
          state_d = S_DONE;
        end else if (!owner_req) begin
          state_d = S_ABORT;
        end
      end
      S_DONE: begin
        ptr_d   = owner_q;
        state_d = S_IDLE;
      end
      S_ABORT: begin
        ptr_d   = owner_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant      = '0;
    done       = '0;
    tmr_value  = '0;
    tmr_valid  = 1'b0;
    tmr_enable = 1'b0;
    busy       = (state_q != S_IDLE);
    unique case (state_q)
      S_LOAD: begin
        tmr_valid = 1'b1;
        tmr_value = owner_value;
        grant     = owner_onehot;
      end
      S_RUN: begin
        tmr_enable = !hold;
        grant      = owner_onehot;
      end
      S_DONE: begin
        grant = owner_onehot;
        done  = owner_onehot;
      end
      // Loading zero flushes the timer so a stale count never leaks to the next owner.
      S_ABORT: begin
        tmr_valid = 1'b1;
        tmr_value = '0;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_timer_scheduler.sv
// tb/tb_timer_scheduler.sv - directed self-checking bench for timer_scheduler
module tb_timer_scheduler;

  localparam int N_REQ = 4;
  localparam int WIDTH = 5;

  logic                   clk = 1'b0;
  logic                   reset;
  logic [N_REQ-1:0]       req;
  logic [N_REQ*WIDTH-1:0] req_value;
  logic                   hold;
  logic [N_REQ-1:0]       grant;
  logic [N_REQ-1:0]       done;
  logic                   busy;
  logic [WIDTH-1:0]       tmr_value;
  logic                   tmr_valid;
  logic                   tmr_enable;
  logic [WIDTH-1:0]       tmr_count;

  logic [N_REQ-1:0]       done_seen;
  logic                   auto_drop;
  int                     n_chk = 0;
  int                     n_pass = 0;

  timer_scheduler #(.N_REQ(N_REQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req        (req),
    .req_value  (req_value),
    .hold       (hold),
    .grant      (grant),
    .done       (done),
    .busy       (busy),
    .tmr_value  (tmr_value),
    .tmr_valid  (tmr_valid),
    .tmr_enable (tmr_enable),
    .tmr_count  (tmr_count)
  );

  always #5 clk = ~clk;

  // External countdown timer that stops at zero.
  always @(posedge clk) begin
    if (reset)                               tmr_count <= '0;
    else if (tmr_valid)                      tmr_count <= tmr_value;
    else if (tmr_enable && tmr_count != '0)  tmr_count <= tmr_count - 1'b1;
  end

  always @(negedge clk) done_seen <= done;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Requesters release req on the edge at which they sample done.
  task automatic adv();
    @(posedge clk);
    #1;
    if (auto_drop) req = req & ~done_seen;
  endtask

  task automatic expect_cycle(input string t, input int c, input logic [3:0] eg,
                              input logic [3:0] ed, input logic eb);
    chk($sformatf("%s grant c%0d", t, c), 32'(grant), 32'(eg));
    chk($sformatf("%s done c%0d", t, c), 32'(done), 32'(ed));
    chk($sformatf("%s busy c%0d", t, c), 32'(busy), 32'(eb));
    chk($sformatf("%s valid_and_enable c%0d", t, c), 32'(tmr_valid & tmr_enable), 32'd0);
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    req       = '0;
    hold      = 1'b0;
    req_value = '0;
    auto_drop = 1'b1;
    adv();
    adv();
    @(negedge clk);
    expect_cycle("rst", 0, 4'b0000, 4'b0000, 1'b0);
    chk("rst valid", 32'(tmr_valid), 32'd0);
    chk("rst enable", 32'(tmr_enable), 32'd0);
    chk("rst value", 32'(tmr_value), 32'd0);
    adv();
    reset = 1'b0;
  endtask

  initial begin
    // Test 1: single request, value 3
    do_reset();
    req_value[4:0] = 5'd3;
    req = 4'b0001;
    for (int c = 0; c <= 7; c++) begin
      @(negedge clk);
      expect_cycle("t1", c, (c >= 1 && c <= 6) ? 4'b0001 : 4'b0000,
                   (c == 6) ? 4'b0001 : 4'b0000, (c >= 1 && c <= 6));
      chk($sformatf("t1 valid c%0d", c), 32'(tmr_valid), 32'(c == 1));
      chk($sformatf("t1 enable c%0d", c), 32'(tmr_enable), 32'(c >= 2 && c <= 5));
      if (c == 1) chk("t1 value", 32'(tmr_value), 32'd3);
      adv();
    end

    // Test 2: all four requesting, round-robin order
    do_reset();
    req_value = {5'd1, 5'd1, 5'd1, 5'd1};
    req = 4'b1111;
    for (int c = 0; c <= 20; c++) begin
      logic [3:0] eg, ed;
      int k, ph;
      eg = '0;
      ed = '0;
      if (c >= 1) begin
        k  = (c - 1) / 5;
        ph = (c - 1) % 5;
        if (ph <= 3) eg = 4'(1 << k);
        if (ph == 3) ed = 4'(1 << k);
      end
      @(negedge clk);
      expect_cycle("t2", c, eg, ed, eg != 4'b0000);
      adv();
    end

    // Test 3: zero delay
    do_reset();
    req = 4'b0001;
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      expect_cycle("t3", c, (c >= 1 && c <= 3) ? 4'b0001 : 4'b0000,
                   (c == 3) ? 4'b0001 : 4'b0000, (c >= 1 && c <= 3));
      if (c < 2) chk($sformatf("t3 enable c%0d", c), 32'(tmr_enable), 32'd0);
      adv();
    end

    // Test 4: value 4 with two hold cycles
    do_reset();
    req_value[4:0] = 5'd4;
    req = 4'b0001;
    for (int c = 0; c <= 10; c++) begin
      hold = (c == 3 || c == 4);
      @(negedge clk);
      expect_cycle("t4", c, (c >= 1 && c <= 9) ? 4'b0001 : 4'b0000,
                   (c == 9) ? 4'b0001 : 4'b0000, (c >= 1 && c <= 9));
      chk($sformatf("t4 enable c%0d", c), 32'(tmr_enable), 32'(c >= 2 && c <= 8 && !hold));
      adv();
    end
    hold = 1'b0;

    // Test 5: owner cancels at count 2, next requester served
    do_reset();
    req_value = {5'd0, 5'd0, 5'd1, 5'd5};
    req = 4'b0011;
    for (int c = 0; c <= 12; c++) begin
      logic [3:0] eg;
      eg = (c >= 1 && c <= 5) ? 4'b0001 : (c >= 8 && c <= 11) ? 4'b0010 : 4'b0000;
      if (c == 5) req[0] = 1'b0;
      @(negedge clk);
      expect_cycle("t5", c, eg, (c == 11) ? 4'b0010 : 4'b0000,
                   (c >= 1 && c <= 6) || (c >= 8 && c <= 11));
      chk($sformatf("t5 valid c%0d", c), 32'(tmr_valid), 32'(c == 1 || c == 6 || c == 8));
      if (c == 6) chk("t5 abort value", 32'(tmr_value), 32'd0);
      if (c == 8) chk("t5 load value", 32'(tmr_value), 32'd1);
      adv();
    end

    // Test 6: reset mid-RUN, pointer restarts at requester 0
    do_reset();
    req_value = {5'd0, 5'd0, 5'd6, 5'd1};
    req = 4'b0011;
    for (int c = 0; c <= 10; c++) begin
      logic [3:0] eg;
      eg = (c >= 1 && c <= 4) ? 4'b0001 : (c >= 6 && c <= 8) ? 4'b0010 :
           (c == 10) ? 4'b0001 : 4'b0000;
      if (c == 6) req[0] = 1'b1;
      reset = (c == 8);
      @(negedge clk);
      expect_cycle("t6", c, eg, (c == 4) ? 4'b0001 : 4'b0000,
                   (c >= 1 && c <= 4) || (c >= 6 && c <= 8) || c == 10);
      if (c == 9) begin
        chk("t6 post-reset valid", 32'(tmr_valid), 32'd0);
        chk("t6 post-reset enable", 32'(tmr_enable), 32'd0);
      end
      if (c == 10) begin
        chk("t6 regrant valid", 32'(tmr_valid), 32'd1);
        chk("t6 regrant value", 32'(tmr_value), 32'd1);
      end
      adv();
    end
    reset = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
